div_sequencer: RTL and testbench



---
 rtl/div_sequencer.sv | 112 +++++++++++
 tb/tb_div_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Sequencer between the multicycle control unit and the Div datapath: launches DIV, commits HI/LO, serves MTHI/MTLO.
// Optional WAIT-state watchdog enabled by defining DIV_TIMEOUT_EN.
module div_sequencer
`ifdef DIV_TIMEOUT_EN
   #(parameter int DIV_MAX_CYCLES = 40)
`endif
(
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] hilo_wdata,
   output logic        busy,
   output logic        done,
   output logic        div_zero_exc,
   output logic        div_timeout,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        div_start,
   output logic [31:0] dividend,
   output logic [31:0] divisor,
   input  logic        div_finished,
   input  logic        div_zero,
   input  logic [31:0] div_quotient,
   input  logic [31:0] div_remainder
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

   state_t state, state_next;
   logic   accept, zero_trap, result_load, timeout_hit;

   assign accept      = (state == S_IDLE) && req;
   assign zero_trap   = (state == S_START) && div_zero;
   assign result_load = (state == S_WAIT) && div_finished;

`ifdef DIV_TIMEOUT_EN
   localparam logic [5:0] CNT_LAST = 6'(DIV_MAX_CYCLES - 1);
   logic [5:0] wait_cnt;

   // A finish in the last allowed WAIT cycle still wins over the timeout.
   assign timeout_hit = (state == S_WAIT) && !div_finished && (wait_cnt == CNT_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt    <= '0;
         div_timeout <= 1'b0;
      end else begin
         div_timeout <= timeout_hit;
         if (state == S_START)
            wait_cnt <= '0;
         else if (state == S_WAIT)
            wait_cnt <= wait_cnt + 6'd1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign div_timeout = 1'b0;
`endif

   // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      // NOTE: default first so no path leaves state_next unassigned (no latch).
      state_next = state;
      case (state)
         S_IDLE:  if (req) state_next = S_START;
         S_START: state_next = div_zero ? S_IDLE : S_WAIT;
         S_WAIT:  if (div_finished || timeout_hit) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != S_IDLE);
      div_start = (state == S_START);
   end

   // Operand, HI/LO and result-pulse registers; MTHI/MTLO only land while idle.
   always_ff @(posedge clock) begin
      if (reset) begin
         dividend     <= '0;
         divisor      <= '0;
         hi_out       <= '0;
         lo_out       <= '0;
         done         <= 1'b0;
         div_zero_exc <= 1'b0;
      end else begin
         done         <= result_load;
         div_zero_exc <= zero_trap;
         if (accept) begin
            dividend <= op_a;
            divisor  <= op_b;
         end
         if (result_load) begin
            lo_out <= div_quotient;
            hi_out <= div_remainder;
         end else if (state == S_IDLE) begin
            if (hi_we) hi_out <= hilo_wdata;
            if (lo_we) lo_out <= hilo_wdata;
         end
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: behavioural Div model, vector table, random ops against a signed-arithmetic reference.
module tb_div_sequencer;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      logic [31:0] lo;
      logic [31:0] hi;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        req, hi_we, lo_we;
   logic [31:0] op_a, op_b, hilo_wdata;
   logic        busy, done, div_zero_exc, div_timeout, div_start;
   logic [31:0] hi_out, lo_out, dividend, divisor;
   logic        div_finished, div_zero;
   logic [31:0] div_quotient, div_remainder;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_hi, m_lo;

   int          div_lat = 1;
   bit          div_hang = 1'b0;
   int          div_cnt;
   bit          div_active;

   div_sequencer dut (
      .clock(clock), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
      .hi_we(hi_we), .lo_we(lo_we), .hilo_wdata(hilo_wdata),
      .busy(busy), .done(done), .div_zero_exc(div_zero_exc), .div_timeout(div_timeout),
      .hi_out(hi_out), .lo_out(lo_out), .div_start(div_start),
      .dividend(dividend), .divisor(divisor),
      .div_finished(div_finished), .div_zero(div_zero),
      .div_quotient(div_quotient), .div_remainder(div_remainder)
   );

   always #5 clock = ~clock;

   // Div block model: results from its operand inputs, finished high in WAIT cycle div_lat.
   always_comb begin
      div_zero      = (divisor == 32'd0);
      div_quotient  = 32'd0;
      div_remainder = 32'd0;
      if (!div_zero && !(dividend == 32'h8000_0000 && divisor == 32'hFFFF_FFFF)) begin
         div_quotient  = $signed(dividend) / $signed(divisor);
         div_remainder = $signed(dividend) % $signed(divisor);
      end
   end

   always @(posedge clock) begin
      if (reset) begin
         div_active   <= 1'b0;
         div_cnt      <= 0;
         div_finished <= 1'b0;
      end else if (div_start && !div_zero) begin
         div_active   <= 1'b1;
         div_cnt      <= 1;
         div_finished <= !div_hang && (div_lat == 1);
      end else if (div_active) begin
         if (div_finished) begin
            div_active   <= 1'b0;
            div_finished <= 1'b0;
         end else begin
            div_cnt      <= div_cnt + 1;
            div_finished <= !div_hang && (div_cnt + 1 == div_lat);
         end
      end
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
   endfunction

   task automatic mt_write(input logic h, input logic l, input logic [31:0] data);
      @(negedge clock);
      hi_we = h; lo_we = l; hilo_wdata = data;
      @(posedge clock); #1;
      hi_we = 1'b0; lo_we = 1'b0;
      if (h) m_hi = data;
      if (l) m_lo = data;
      check32("mt_hi", hi_out, m_hi);
      check32("mt_lo", lo_out, m_lo);
   endtask

   // Issues one DIV and follows it to its terminating pulse; returns in that pulse cycle.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int lat,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi, input string tag);
      int n;
      bit inflight_ok;
      div_lat = lat;
      @(negedge clock);
      req = 1'b1; op_a = a; op_b = b;
      @(posedge clock); #1;
      req = 1'b0; op_a = $urandom; op_b = $urandom;
      check1({tag, "_c1_busy"}, busy, 1'b1);
      check1({tag, "_c1_start"}, div_start, 1'b1);
      n = 0;
      inflight_ok = 1'b1;
      do begin
         @(posedge clock); #1;
         n++;
         if (!(done || div_zero_exc || div_timeout) && (!busy || div_start)) inflight_ok = 1'b0;
      end while (!(done || div_zero_exc || div_timeout) && n < 200);
      check1({tag, "_inflight"}, inflight_ok, 1'b1);
      check1({tag, "_end_busy"}, busy, 1'b0);
      check1({tag, "_end_start"}, div_start, 1'b0);
      check1({tag, "_timeout"}, div_timeout, 1'b0);
      check32({tag, "_opa_held"}, dividend, a);
      check32({tag, "_opb_held"}, divisor, b);
      if (b == 32'd0) begin
         check1({tag, "_zexc"}, div_zero_exc, 1'b1);
         check1({tag, "_zdone"}, done, 1'b0);
         check32({tag, "_zlat"}, 32'(n), 32'd1);
      end else begin
         m_lo = exp_lo; m_hi = exp_hi;
         check1({tag, "_done"}, done, 1'b1);
         check1({tag, "_zexc"}, div_zero_exc, 1'b0);
         check32({tag, "_lat"}, 32'(n), 32'(lat + 1));
      end
      check32({tag, "_lo"}, lo_out, m_lo);
      check32({tag, "_hi"}, hi_out, m_hi);
   endtask

   initial begin : stim
      vec_t        vecs[8];
      logic [31:0] a, b, q, r;
      int          n;

      vecs[0] = '{32'd100,        32'd7,          4, 32'd14,         32'd2};
      vecs[1] = '{32'hFFFF_FF9C,  32'd7,          6, 32'hFFFF_FFF2,  32'hFFFF_FFFE};
      vecs[2] = '{32'd5,          32'd9,          1, 32'd0,          32'd5};
      vecs[3] = '{32'd7,          32'hFFFF_FFFE,  2, 32'hFFFF_FFFD,  32'd1};
      vecs[4] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  3, 32'd3,          32'hFFFF_FFFF};
      vecs[5] = '{32'h8000_0000,  32'd2,          1, 32'hC000_0000,  32'd0};
      vecs[6] = '{32'd0,          32'd5,         33, 32'd0,          32'd0};
      vecs[7] = '{32'hFFFF_FFFF,  32'd1,          2, 32'hFFFF_FFFF,  32'd0};

      reset = 1'b1; req = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op_a = '0; op_b = '0; hilo_wdata = '0;
      m_hi = '0; m_lo = '0;
      repeat (3) @(posedge clock);
      #1;
      check1("rst_busy", busy, 1'b0);
      check1("rst_done", done, 1'b0);
      check1("rst_zexc", div_zero_exc, 1'b0);
      check1("rst_tmo", div_timeout, 1'b0);
      check1("rst_start", div_start, 1'b0);
      check32("rst_hi", hi_out, 32'd0);
      check32("rst_lo", lo_out, 32'd0);
      check32("rst_dividend", dividend, 32'd0);
      check32("rst_divisor", divisor, 32'd0);
      reset = 1'b0;

      // Table vectors back to back: each req lands in the previous done cycle.
      for (int i = 0; i < 8; i++)
         run_div(vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].lo, vecs[i].hi, $sformatf("vec%0d", i));

      // Divide by zero leaves preloaded HI/LO intact.
      mt_write(1'b1, 1'b1, 32'h0000_AAAA);
      mt_write(1'b0, 1'b1, 32'h0000_5555);
      run_div(32'd42, 32'd0, 1, '0, '0, "zero");
      @(posedge clock); #1;
      check1("zero_pulse_single", div_zero_exc, 1'b0);
      check32("zero_hi_keep", hi_out, 32'h0000_AAAA);

      // MTHI and a stray req while busy are dropped; result lands afterwards.
      div_lat = 10;
      @(negedge clock);
      req = 1'b1; op_a = 32'd100; op_b = 32'd7;
      @(posedge clock); #1;
      req = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      hi_we = 1'b1; hilo_wdata = 32'h0000_1234;
      req = 1'b1; op_a = 32'd9; op_b = 32'd3;
      @(posedge clock); #1;
      hi_we = 1'b0; req = 1'b0;
      check32("busy_mthi_drop", hi_out, m_hi);
      check32("busy_req_drop_a", dividend, 32'd100);
      check32("busy_req_drop_b", divisor, 32'd7);
      n = 0;
      while (!done && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      check1("busy_done", done, 1'b1);
      check32("busy_hi", hi_out, 32'd2);
      check32("busy_lo", lo_out, 32'd14);
      m_hi = 32'd2; m_lo = 32'd14;
      mt_write(1'b1, 1'b0, 32'h0000_1234);
      check1("done_single", done, 1'b0);

      // req and MTHI in the same idle cycle: MTHI visible in START, result overwrites HI.
      div_lat = 2;
      @(negedge clock);
      req = 1'b1; op_a = 32'd50; op_b = 32'd8; hi_we = 1'b1; hilo_wdata = 32'hBEEF_0001;
      @(posedge clock); #1;
      req = 1'b0; hi_we = 1'b0;
      check32("same_cycle_mthi", hi_out, 32'hBEEF_0001);
      repeat (3) @(posedge clock);
      #1;
      check1("same_cycle_done", done, 1'b1);
      check32("same_cycle_hi", hi_out, 32'd2);
      check32("same_cycle_lo", lo_out, 32'd6);
      m_hi = 32'd2; m_lo = 32'd6;

      // Reset in WAIT cycle 5.
      div_lat = 20;
      @(negedge clock);
      req = 1'b1; op_a = 32'd77; op_b = 32'd5;
      @(posedge clock); #1;
      req = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      check1("pre_rst_busy", busy, 1'b1);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check1("mid_rst_busy", busy, 1'b0);
      check1("mid_rst_start", div_start, 1'b0);
      check1("mid_rst_done", done, 1'b0);
      check32("mid_rst_hi", hi_out, 32'd0);
      check32("mid_rst_lo", lo_out, 32'd0);
      check32("mid_rst_dividend", dividend, 32'd0);
      m_hi = '0; m_lo = '0;
      run_div(32'd100, 32'd7, 3, 32'd14, 32'd2, "post_rst");

`ifdef DIV_TIMEOUT_EN
      div_hang = 1'b1;
      @(negedge clock);
      req = 1'b1; op_a = 32'd100; op_b = 32'd3;
      @(posedge clock); #1;
      req = 1'b0;
      n = 0;
      while (!div_timeout && !done && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      check1("tmo_pulse", div_timeout, 1'b1);
      check32("tmo_lat", 32'(n), 32'd41);
      check1("tmo_busy", busy, 1'b0);
      check32("tmo_hi", hi_out, m_hi);
      check32("tmo_lo", lo_out, m_lo);
      div_hang = 1'b0;
`endif

      // Random ops against the arithmetic reference.
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         end else begin
            a = $urandom;
            case ($urandom_range(0, 7))
               0:       b = 32'd0;
               1, 2:    b = 32'($urandom_range(1, 15));
               3:       b = -32'($urandom_range(1, 15));
               default: b = $urandom;
            endcase
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            q = '0; r = '0;
            if (b != 32'd0) ref_div(a, b, q, r);
            run_div(a, b, $urandom_range(1, 12), q, r, $sformatf("rnd%0d", i));
         end
      end

      @(posedge clock); #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
